bm_seq_divide: RTL and testbench

//  Iterative restoring unsigned divider microbenchmark. It is the inverse-operation

---
 rtl/bm_div_pkg.sv | 15 +
 rtl/bm_div_step.sv | 31 +++
 rtl/bm_seq_divide.sv | 122 ++++++++++++
 tb/tb_bm_seq_divide.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bm_div_pkg.sv
// Shared definitions for the sequential benchmark blocks.
package bm_div_pkg;

    // State encodings; S_DONE is also used by other sequential benchmarks.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = S_IDLE,
        StRun  = S_RUN,
        StDone = S_DONE
    } div_state_e;

endpackage

// File: rtl/bm_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and record the quotient bit.
module bm_div_step #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] r_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] r_out,
    output logic [DATA_W-1:0] q_out
);

    // Shifted remainder carries one extra bit so the compare cannot overflow.
    logic [DATA_W:0]   p;
    logic [DATA_W-1:0] diff;

    // Compare/subtract and shift the quotient bit in at the LSB.
    always_comb begin
        p    = {r_in, q_in[DATA_W-1]};
        // Only taken when p >= divisor, so the result always fits in DATA_W bits.
        diff = p[DATA_W-1:0] - divisor;
        if (p >= {1'b0, divisor}) begin
            r_out = diff;
            q_out = {q_in[DATA_W-2:0], 1'b1};
        end else begin
            r_out = p[DATA_W-1:0];
            q_out = {q_in[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/bm_seq_divide.sv
// Iterative restoring unsigned divider: one quotient bit per clock, DATA_W steps per
// operation, with registered done/busy and held results.
module bm_seq_divide
    import bm_div_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] q_work_q, q_work_d;
    logic [DATA_W-1:0] r_work_q, r_work_d;
    logic [DATA_W-1:0] div_q, div_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [DATA_W-1:0] step_r, step_q;

    bm_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .r_in    (r_work_q),
        .q_in    (q_work_q),
        .divisor (div_q),
        .r_out   (step_r),
        .q_out   (step_q)
    );

    // State, counter, working and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            q_work_q <= '0;
            r_work_q <= '0;
            div_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_work_q <= q_work_d;
            r_work_q <= r_work_d;
            div_q    <= div_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    // Next-state and datapath control; results only change on entry to DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_work_d = q_work_q;
        r_work_d = r_work_q;
        div_d    = div_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        div_d    = divisor;
                        q_work_d = dividend;
                        r_work_d = '0;
                        cnt_d    = '0;
                        state_d  = StRun;
                    end else begin
                        // Divide by zero completes immediately with saturated quotient.
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                q_work_d = step_q;
                r_work_d = step_r;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    quot_d  = step_q;
                    rem_d   = step_r;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status flags decode the registered state, so they have no path from inputs.
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_bm_seq_divide.sv
// Directed and random checks of the sequential divider against hand values and a/b.
module tb_bm_seq_divide;

    localparam int DW = 8;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    bm_seq_divide #(
        .DATA_W (DW),
        .CNT_W  (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request in an IDLE cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clock);
        while (done) @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = DW'($urandom);
    endtask

    // Edges from now until done is seen, and busy cycles before it; bounded.
    task automatic wait_done(output int lat, output int busy_cnt, output bit timed_out);
        lat       = 0;
        busy_cnt  = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat       = i;
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clock);
            #1;
        end
    endtask

    // Latency counts edges after the start edge: DW normally, 0 (next cycle) for /0.
    task automatic run_check(input string name, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [DW-1:0] eq,
                             input logic [DW-1:0] er, input logic edbz);
        int lat, bc;
        bit to;
        issue(a, b);
        wait_done(lat, bc, to);
        check({name, "_timeout"}, 32'(to), 0);
        check({name, "_lat"}, lat, edbz ? 0 : DW);
        check({name, "_busy"}, bc, edbz ? 0 : DW);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    endtask

    initial begin
        int lat, bc, extra;
        bit to;
        logic [DW-1:0] a, b, eq, er;

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        run_check("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run_check("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_check("d0_255", 8'd0, 8'd255, 8'd0, 8'd0, 1'b0);
        run_check("d7_9", 8'd7, 8'd9, 8'd0, 8'd7, 1'b0);
        run_check("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        run_check("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

        // A start pulse mid-RUN must be ignored and not queued.
        issue(8'd200, 8'd3);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 1);
        wait_done(lat, bc, to);
        check("ign_timeout", 32'(to), 0);
        check("ign_q", quotient, 66);
        check("ign_r", remainder, 2);
        extra = 0;
        repeat (15) begin
            @(posedge clock);
            #1;
            if (done) extra++;
        end
        check("ign_extra_done", extra, 0);

        // Asynchronous reset in the middle of an operation.
        issue(8'd100, 8'd7);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("pre_rst_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dbz", 32'(div_by_zero), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        extra = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (done || busy) extra++;
        end
        check("post_rst_quiet", extra, 0);
        run_check("post_rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

        // Back-to-back: request in the IDLE cycle right after done.
        run_check("b2b_a", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0);
        @(posedge clock);
        #1;
        check("b2b_idle", 32'(done | busy), 0);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b_accept", 32'(busy), 1);
        check("b2b_hold_q", quotient, 3);
        check("b2b_hold_r", remainder, 2);
        wait_done(lat, bc, to);
        check("b2b_timeout", 32'(to), 0);
        check("b2b_lat", lat, DW);
        check("b2b_q", quotient, 10);
        check("b2b_r", remainder, 0);

        // Random sweep against a reference divide.
        for (int n = 0; n < 1000; n++) begin
            a = DW'($urandom_range(0, 255));
            b = DW'($urandom_range(0, 255));
            if (n % 50 == 0) b = '0;
            eq = (b == 0) ? 8'hFF : a / b;
            er = (b == 0) ? a : a % b;
            run_check("sweep", a, b, eq, er, b == 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
